// File: rtl/axis_adc_avg.sv
// Streaming block averager: sums 2^L signed ADC samples, emits the floored
// mean as a sign-extended AXI-Stream word, and marks frame boundaries with tlast.
module axis_adc_avg #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_LOG2_N = 8,
  parameter int FRAME_LEN  = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  log2_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int CNT_W = MAX_LOG2_N + 1;
  localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [3:0]      MAX_L    = 4'(MAX_LOG2_N);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_LEN - 1);

  logic                    run;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [CNT_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        n_minus1;
  logic [3:0]              l_reg;
  logic [3:0]              l_new;
  logic [3:0]              l_eff;
  logic [FC_W-1:0]         frame_cnt;
  logic                    out_valid;
  logic [31:0]             out_data;
  logic                    s_hs;
  logic                    m_hs;
  logic                    first;
  logic                    window_done;
  logic                    unused_tdata;

  assign unused_tdata = ^s_axis_tdata[31:DATA_WIDTH];

  // run holds ready low during reset and rises on the first edge after release.
  assign s_axis_tready = run && !(out_valid && !m_axis_tready);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = out_valid && m_axis_tready;

  assign first      = (win_cnt == '0);
  assign sample_ext = ACC_W'($signed(s_axis_tdata[DATA_WIDTH-1:0]));
  assign l_new      = (log2_n > MAX_L) ? MAX_L : log2_n;
  // NOTE: the first sample of a window must already see the new exponent, so
  // the live (clamped) input is used until l_reg has captured it.
  assign l_eff       = first ? l_new : l_reg;
  assign n_minus1    = (CNT_W'(1) << l_eff) - CNT_W'(1);
  assign sum         = first ? sample_ext : acc + sample_ext;
  assign shifted     = sum >>> l_eff;
  assign window_done = s_hs && (win_cnt == n_minus1);

  // NOTE: every register here, including the accumulator, is cleared by the
  // asynchronous reset so a partial window can never leak into the next run.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run       <= 1'b0;
      acc       <= '0;
      win_cnt   <= '0;
      l_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (s_hs) begin
        acc     <= sum;
        win_cnt <= window_done ? '0 : win_cnt + 1'b1;
        if (first) l_reg <= l_new;
      end
      if (window_done) begin
        out_valid <= 1'b1;
        out_data  <= 32'(shifted);
      end else if (m_hs) begin
        out_valid <= 1'b0;
      end
      if (m_hs) frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_valid && (frame_cnt == FC_LAST);

endmodule

// File: tb/tb_axis_adc_avg.sv
// Directed bench for axis_adc_avg: vector table for windowed averages plus
// hand-written backpressure, clamping, reset and framing sequences.
module tb_axis_adc_avg;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  log2_n = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axis_adc_avg #(.DATA_WIDTH(24), .MAX_LOG2_N(8), .FRAME_LEN(4)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .log2_n        (log2_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  typedef struct {
    logic [3:0]  l;
    logic [31:0] din;
    logic        has_out;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one sample and return 1 time unit after the edge that accepts it.
  task automatic push(input logic [31:0] d);
    int waited = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    check("push_ready", 32'(s_tready), 32'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    areset   = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast",  32'(m_tlast),  32'd0);
    check("rst_tdata",  m_tdata,       32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rel_tready_pre_edge", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #1;
    check("rel_tready_post_edge", 32'(s_tready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;

    vecs[0]  = '{4'd0, 32'h0080_0000, 1'b1, 32'hFF80_0000};
    vecs[1]  = '{4'd0, 32'h007F_FFFF, 1'b1, 32'h007F_FFFF};
    vecs[2]  = '{4'd2, 32'd10,        1'b0, 32'd0};
    vecs[3]  = '{4'd2, 32'd11,        1'b0, 32'd0};
    vecs[4]  = '{4'd2, 32'd12,        1'b0, 32'd0};
    vecs[5]  = '{4'd2, 32'd14,        1'b1, 32'd11};
    vecs[6]  = '{4'd2, 32'hAAFF_FFFF, 1'b0, 32'd0};
    vecs[7]  = '{4'd2, 32'd0,         1'b0, 32'd0};
    vecs[8]  = '{4'd2, 32'd0,         1'b0, 32'd0};
    vecs[9]  = '{4'd2, 32'd0,         1'b1, 32'hFFFF_FFFF};
    vecs[10] = '{4'd1, 32'hFFFF_FFFD, 1'b0, 32'd0};
    vecs[11] = '{4'd1, 32'd0,         1'b1, 32'hFFFF_FFFE};
    vecs[12] = '{4'd1, 32'd5,         1'b0, 32'd0};
    vecs[13] = '{4'd1, 32'd6,         1'b1, 32'd5};
    vecs[14] = '{4'd0, 32'h1200_0005, 1'b1, 32'd5};
    vecs[15] = '{4'd0, 32'h5A00_0000, 1'b1, 32'd0};

    repeat (2) @(posedge aclk);
    do_reset();

    // Table: back-to-back samples, output checked one cycle after acceptance.
    for (int i = 0; i < 16; i++) begin
      log2_n = vecs[i].l;
      push(vecs[i].din);
      check($sformatf("vec%0d_valid", i), 32'(m_tvalid), 32'(vecs[i].has_out));
      if (vecs[i].has_out) check($sformatf("vec%0d_data", i), m_tdata, vecs[i].exp_out);
    end
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    check("idle_valid", 32'(m_tvalid), 32'd0);

    // Backpressure: one pending word stalls the input without losing the next sample.
    log2_n   = 4'd0;
    m_tready = 1'b0;
    push(32'd100);
    check("bp_first_data", m_tdata, 32'd100);
    s_tdata  = 32'd200;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("bp_stall%0d_tready", i), 32'(s_tready), 32'd0);
      check($sformatf("bp_stall%0d_data", i), m_tdata, 32'd100);
      check($sformatf("bp_stall%0d_valid", i), 32'(m_tvalid), 32'd1);
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    push(32'd200);
    check("bp_second_valid", 32'(m_tvalid), 32'd1);
    check("bp_second_data", m_tdata, 32'd200);
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    check("bp_drained", 32'(m_tvalid), 32'd0);

    // Clamping: log2_n=15 means a 256-sample window; a change after sample 3 waits.
    log2_n = 4'd15;
    early  = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 3) log2_n = 4'd0;
      push(32'h007F_FFFF);
      if (i < 255 && m_tvalid) early++;
    end
    check("clamp_no_early", 32'(early), 32'd0);
    check("clamp_valid", 32'(m_tvalid), 32'd1);
    check("clamp_data", m_tdata, 32'h007F_FFFF);
    push(32'd5);
    check("new_l_valid", 32'(m_tvalid), 32'd1);
    check("new_l_data", m_tdata, 32'd5);

    // Reset mid-window discards the partial sum.
    log2_n = 4'd3;
    for (int i = 0; i < 5; i++) push(32'd100);
    do_reset();
    early = 0;
    for (int i = 0; i < 8; i++) begin
      push(32'd2);
      if (i < 7 && m_tvalid) early++;
    end
    check("rst_win_no_early", 32'(early), 32'd0);
    check("rst_win_valid", 32'(m_tvalid), 32'd1);
    check("rst_win_data", m_tdata, 32'd2);

    // Framing: FRAME_LEN=4, tlast on words 4 and 8 of a fresh frame.
    do_reset();
    log2_n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      push(32'(i + 1));
      check($sformatf("frame_w%0d_data", i + 1), m_tdata, 32'(i + 1));
      check($sformatf("frame_w%0d_last", i + 1), 32'(m_tlast), 32'((i == 3) || (i == 7)));
    end
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    check("frame_drained", 32'(m_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_adc_avg.md
AXIS_ADC_AVG -- requirements
Module: axis_adc_avg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning the width of the signed ADC sample in s_axis_tdata[DATA_WIDTH-1:0].
REQ-002 SHALL have parameter MAX_LOG2_N, default 8, meaning the largest supported averaging exponent.
REQ-003 SHALL have parameter FRAME_LEN, default 1024, meaning the number of output words per frame; legal range is 1 or more.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port areset, input, 1, reset; asynchronous assert, active-high.
REQ-006 SHALL have port log2_n, input, 4, the averaging exponent; N = 2^log2_n.
REQ-007 SHALL have port s_axis_tdata, input, 32, the sample word from the ADC interface; bits above DATA_WIDTH are ignored.
REQ-008 SHALL have port s_axis_tvalid, input, 1, meaning a sample is valid.
REQ-009 SHALL have port s_axis_tready, output, 1, meaning the block accepts a sample.
REQ-010 SHALL have port m_axis_tdata, output, 32, the averaged sample, sign-extended.
REQ-011 SHALL have port m_axis_tvalid, output, 1, meaning the output word is valid.
REQ-012 SHALL have port m_axis_tready, input, 1, the downstream accept.
REQ-013 SHALL have port m_axis_tlast, output, 1, marking the last word of a frame.

Function
REQ-014 SHALL treat s_axis_tdata[DATA_WIDTH-1:0] as two's-complement and sign-extend it into an accumulator of DATA_WIDTH+MAX_LOG2_N bits; the accumulator SHALL never overflow.
REQ-015 SHALL clamp the effective exponent L to MAX_LOG2_N when log2_n exceeds MAX_LOG2_N.
REQ-016 SHALL latch L only when the first sample of a window is accepted; changes to log2_n mid-window SHALL take effect at the next window.
REQ-017 SHALL drive s_axis_tready = !(m_axis_tvalid && !m_axis_tready), so input stalls only while an output word is pending and not being accepted.
REQ-018 SHALL accept a sample on the cycle s_axis_tvalid && s_axis_tready; on that cycle the accumulator loads the sample if the window count is 0 and otherwise adds the sample.
REQ-019 SHALL, on acceptance of the N-th sample of a window, register m_axis_tdata = sign-extended (window sum >>> L) and set m_axis_tvalid on the following cycle, which is 1-cycle latency, then reset the window count to 0.
REQ-020 SHALL use arithmetic right shift, i.e. floor rounding toward negative infinity.
REQ-021 SHALL, when L=0, pass each sample through sign-extended with 1-cycle latency.
REQ-022 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-023 SHALL clear m_axis_tvalid after a handshake unless a new result is loaded in the same cycle, in which case m_axis_tvalid stays 1 with the new data, giving full throughput at L=0.
REQ-024 SHALL count output handshakes modulo FRAME_LEN and assert m_axis_tlast with the FRAME_LEN-th word of each frame; the count wraps to 0 after that handshake.
REQ-025 SHALL, when FRAME_LEN=1, assert m_axis_tlast on every word.
REQ-026 SHALL not drop or duplicate samples under any combination of tvalid and tready.

Reset
REQ-027 SHALL, while areset=1, force s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, the accumulator to 0, the window count to 0, the frame count to 0 and L to 0.
REQ-028 SHALL, on reset asserted mid-window or with a word pending, discard the partial window and pending word; after release the first accepted sample starts a new window and frame.
REQ-029 SHALL assert s_axis_tready on the first aclk edge after areset deasserts.

Verification
REQ-030 SHALL verify passthrough: log2_n=0, tready=1, input 24'h800000 then 24'h7FFFFF -> outputs 32'hFF800000 then 32'h007FFFFF, each 1 cycle after acceptance, back-to-back.
REQ-031 SHALL verify averaging: log2_n=2, input 10, 11, 12, 14 -> one output of 11 (floor of 47/4); input -1, 0, 0, 0 -> output 32'hFFFFFFFF.
REQ-032 SHALL verify backpressure: log2_n=0, m_axis_tready held 0 for 5 cycles -> s_axis_tready=0 after the first result, m_axis_tdata stable, and no sample lost once m_axis_tready rises.
REQ-033 SHALL verify clamping: log2_n=15 with 256 samples of 24'h7FFFFF -> single output 32'h007FFFFF; a log2_n change after sample 3 does not alter that window.
REQ-034 SHALL verify framing: FRAME_LEN=4, log2_n=0, 9 samples -> m_axis_tlast on outputs 4 and 8 only.
REQ-035 SHALL verify reset mid-window: log2_n=3, 5 samples, pulse areset -> all outputs 0 during reset; next 8 samples of value 2 -> output 2.
